// File: rtl/piso_tx_scheduler.sv
// Two-requester round-robin scheduler feeding a PISO shift register.
// Accepted words go out MSB-first, framed by sframe and followed by GAP idle cycles.
module piso_tx_scheduler #(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             sl,
    output logic             dout,
    output logic             sframe,
    output logic             grant_id,
    output logic             busy,
    output logic             done
);
    localparam int BCW = $clog2(WIDTH + 1);
    localparam int GCW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GCW-1:0]   gap_cnt_q, gap_cnt_d;
    logic             last_grant_q, last_grant_d;
    logic             grant_id_q, grant_id_d;
    logic             dout_q, dout_d;
    logic             sframe_q, sframe_d;
    logic             done_q, done_d;
    logic             grant0, grant1;
    logic [WIDTH-1:0] sel_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            dout_q       <= 1'b0;
            sframe_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            dout_q       <= dout_d;
            sframe_q     <= sframe_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        dout_d       = dout_q;
        sframe_d     = sframe_q;
        done_d       = 1'b0;
        grant0       = 1'b0;
        grant1       = 1'b0;
        sel_data     = '0;
        case (state_q)
            S_IDLE: begin
                grant0   = req0_valid && (!req1_valid || last_grant_q);
                grant1   = req1_valid && (!req0_valid || !last_grant_q);
                sel_data = grant1 ? req1_data : req0_data;
                if (grant0 || grant1) begin
                    // The MSB leaves on the load edge so the first bit appears one cycle after accept.
                    dout_d       = sel_data[WIDTH-1];
                    shreg_d      = sel_data << 1;
                    sframe_d     = 1'b1;
                    bit_cnt_d    = BCW'(1);
                    last_grant_d = grant1;
                    grant_id_d   = grant1;
                    state_d      = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bit_cnt_q == BCW'(WIDTH)) begin
                    dout_d    = 1'b0;
                    sframe_d  = 1'b0;
                    gap_cnt_d = '0;
                    state_d   = (GAP > 0) ? S_GAP : S_IDLE;
                end else begin
                    dout_d    = shreg_q[WIDTH-1];
                    shreg_d   = shreg_q << 1;
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    done_d    = (bit_cnt_q == BCW'(WIDTH - 1));
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GCW'(GAP - 1)) begin
                    gap_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GCW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign sl         = grant0 | grant1;
    assign dout       = dout_q;
    assign sframe     = sframe_q;
    assign grant_id   = grant_id_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Drives two schedulers (GAP=1 and GAP=0) from shared requesters and checks each
// cycle against a frame-timing model built from accept-cycle arithmetic.
module tb_piso_tx_scheduler;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0] req0_data = '0, req1_data = '0;

    logic a_r0, a_r1, a_sl, a_dout, a_sf, a_gid, a_busy, a_done;
    logic b_r0, b_r1, b_sl, b_dout, b_sf, b_gid, b_busy, b_done;

    always #5 clk = ~clk;

    piso_tx_scheduler #(.WIDTH(W), .GAP(1)) u_gap1 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(a_r0),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(a_r1),
        .sl(a_sl), .dout(a_dout), .sframe(a_sf), .grant_id(a_gid),
        .busy(a_busy), .done(a_done)
    );

    piso_tx_scheduler #(.WIDTH(W), .GAP(0)) u_gap0 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(b_r0),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(b_r1),
        .sl(b_sl), .dout(b_dout), .sframe(b_sf), .grant_id(b_gid),
        .busy(b_busy), .done(b_done)
    );

    // Model: each DUT remembers the cycle of its last accept; all outputs follow from the offset.
    int           gapv[2]  = '{1, 0};
    int           acc_cyc[2];
    logic [W-1:0] word[2];
    bit           last_g[2];
    bit           gid[2];
    int           cyc   = 0;
    int           tests = 0;
    int           fails = 0;

    task automatic model_reset(input int g);
        acc_cyc[g] = -1000;
        word[g]    = '0;
        last_g[g]  = 1'b1;
        gid[g]     = 1'b0;
    endtask

    task automatic step(input bit v0, input bit v1, input logic [W-1:0] x0,
                        input logic [W-1:0] x1, input bit r, input string tag);
        int       k;
        bit       idle, e0, e1, e_dout, e_sf, e_done;
        logic [7:0] exp_v, obs_v;
        @(posedge clk);
        #1;
        rst        = r;
        req0_valid = v0;
        req1_valid = v1;
        req0_data  = x0;
        req1_data  = x1;
        @(negedge clk);
        cyc++;
        for (int g = 0; g < 2; g++) begin
            if (r) model_reset(g);
            k      = cyc - acc_cyc[g];
            idle   = (k > W + gapv[g]);
            e0     = idle && v0 && (!v1 || last_g[g]);
            e1     = idle && v1 && (!v0 || !last_g[g]);
            e_sf   = (k >= 1) && (k <= W);
            e_dout = e_sf ? word[g][W-k] : 1'b0;
            e_done = (k == W);
            exp_v  = {e0, e1, e0 | e1, e_dout, e_sf, gid[g], !idle, e_done};
            obs_v  = (g == 0) ? {a_r0, a_r1, a_sl, a_dout, a_sf, a_gid, a_busy, a_done}
                              : {b_r0, b_r1, b_sl, b_dout, b_sf, b_gid, b_busy, b_done};
            tests++;
            assert (obs_v === exp_v)
            else begin
                fails++;
                $error("FAIL %s cyc=%0d gap=%0d {r0,r1,sl,dout,sframe,gid,busy,done} got=%b exp=%b",
                       tag, cyc, gapv[g], obs_v, exp_v);
            end
            if (!r && (e0 || e1)) begin
                acc_cyc[g] = cyc;
                word[g]    = e1 ? x1 : x0;
                last_g[g]  = e1;
                gid[g]     = e1;
            end
        end
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
        repeat (3) step(0, 0, '0, '0, 1, "reset");

        // Single frame 1011 from req0, then idle out the gap.
        step(1, 0, 4'b1011, '0, 0, "single_accept");
        repeat (7) step(0, 0, '0, '0, 0, "single_frame");

        // Both requesters always valid: grants alternate.
        repeat (26) step(1, 1, 4'hA, 4'h5, 0, "both_alt");

        // req1 alone first after reset, then both.
        step(0, 0, '0, '0, 1, "reset2");
        step(0, 1, 4'h3, 4'hC, 0, "req1_only");
        repeat (16) step(1, 1, 4'h3, 4'hC, 0, "both_after_r1");

        // req0 held valid with changing data.
        repeat (14) step(1, 0, 4'($urandom), '0, 0, "req0_held");

        // Reset during the second bit, then a pending req0 restarts cleanly.
        step(0, 0, '0, '0, 1, "reset3");
        step(1, 0, 4'b1101, '0, 0, "pre_abort_accept");
        step(1, 0, 4'b0110, '0, 0, "first_bit");
        step(1, 0, 4'b0110, '0, 1, "abort_rst");
        repeat (8) step(1, 0, 4'b0110, '0, 0, "after_abort");

        // Valid raised mid-frame with data changing until the accept.
        step(0, 0, '0, '0, 1, "reset4");
        step(1, 0, 4'h9, '0, 0, "accept_r0");
        for (int i = 0; i < 8; i++) step(0, 1, '0, 4'(i + 2), 0, "wait_during_shift");

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 400; i++)
            step(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
                 ($urandom_range(0, 59) == 0), "random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
